// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between the fetch (I) and load/store (D) ports,
// D-priority with a starvation bound for I, and fetch results that a redirect discards.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  input  logic        i_flush,
  output logic        i_valid,
  output logic [63:0] i_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_valid,
  output logic [63:0] d_rdata,
  output logic        m_req,
  output logic        m_write,
  output logic [63:0] m_addr,
  output logic [63:0] m_wdata,
  output logic [2:0]  m_funct3,
  input  logic        m_ack,
  input  logic [63:0] m_rdata
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, I_DROP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] starve, starve_nx;
  logic grant_i, grant_d;
  always_comb begin
    grant_i = state == IDLE && i_req && (!d_req || starve == SMAX);
    grant_d = state == IDLE && d_req && !grant_i;
    state_nx = state;
    starve_nx = starve;
    if (state == IDLE) begin
      state_nx = grant_i ? I_BUSY : grant_d ? D_BUSY : IDLE;
      starve_nx = (grant_i || !i_req) ? '0 : (starve == SMAX) ? starve : starve + 1'b1;
    end else if (m_ack)
      state_nx = IDLE;
    else if (state == I_BUSY && i_flush)
      state_nx = I_DROP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      starve   <= '0;
      m_write  <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_funct3 <= '0;
    end else begin
      state  <= state_nx;
      starve <= starve_nx;
      if (grant_d) begin
        m_write  <= d_write;
        m_addr   <= d_addr;
        m_wdata  <= d_wdata;
        m_funct3 <= d_funct3;
      end else if (grant_i) begin
        m_write  <= 1'b0;
        m_addr   <= i_addr;
        m_wdata  <= '0;
        m_funct3 <= 3'b011;
      end
    end
  end
  // The bus transaction stays requested through I_DROP; only the fetch result is discarded.
  assign m_req   = !rst && state != IDLE;
  assign i_valid = !rst && state == I_BUSY && m_ack && !i_flush;
  assign d_valid = !rst && state == D_BUSY && m_ack;
  assign i_rdata = i_valid ? m_rdata : '0;
  assign d_rdata = d_valid ? m_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic, checked every cycle against a
// transaction-level model of the shared bus (owner, pending command, starvation count).
module tb_mem_port_arbiter;
  localparam int STARVE_MAX = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_req = 1'b0, i_flush = 1'b0, d_req = 1'b0, d_write = 1'b0, m_ack = 1'b0;
  logic [63:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [2:0] d_funct3 = '0;
  logic i_valid, d_valid, m_req, m_write;
  logic [63:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [2:0] m_funct3;
  int n_tests = 0, n_fail = 0;
  bit mbusy = 0, mfetch = 0, mdrop = 0;
  int mstarve = 0;
  logic mw = 0;
  logic [63:0] maddr = '0, mwd = '0;
  logic [2:0] mf3 = '0;
  bit last_iv = 0, last_dv = 0, last_fl = 0, last_rst = 0;
  byte seen[$];

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_funct3(m_funct3),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] seen_str();
    logic [63:0] s = '0;
    foreach (seen[k]) s = {s[55:0], seen[k]};
    return s;
  endfunction

  // Compare this cycle's outputs with the model, then advance the model across the clock edge.
  task automatic step();
    logic e_iv, e_dv;
    #1;
    e_iv = !rst && mbusy && mfetch && !mdrop && m_ack && !i_flush;
    e_dv = !rst && mbusy && !mfetch && m_ack;
    check("m_req", 64'(m_req), 64'(!rst && mbusy));
    check("m_write", 64'(m_write), 64'(mw));
    check("m_addr", m_addr, maddr);
    check("m_wdata", m_wdata, mwd);
    check("m_funct3", 64'(m_funct3), 64'(mf3));
    check("i_valid", 64'(i_valid), 64'(e_iv));
    check("d_valid", 64'(d_valid), 64'(e_dv));
    check("one_valid", 64'(i_valid && d_valid), 64'(0));
    if (e_iv) check("i_rdata", i_rdata, m_rdata);
    if (e_dv && !mw) check("d_rdata", d_rdata, m_rdata);
    if (i_valid) seen.push_back("I");
    if (d_valid) seen.push_back("D");
    last_iv = i_valid;
    last_dv = d_valid;
    if (rst) begin
      mbusy = 0; mstarve = 0; mw = 0; maddr = '0; mwd = '0; mf3 = '0;
    end else if (!mbusy) begin
      if (i_req && (!d_req || mstarve >= STARVE_MAX)) begin
        mbusy = 1; mfetch = 1; mdrop = 0; mstarve = 0;
        mw = 0; maddr = i_addr; mwd = '0; mf3 = 3'b011;
      end else if (d_req) begin
        mbusy = 1; mfetch = 0; mdrop = 0;
        mstarve = i_req ? (mstarve < STARVE_MAX ? mstarve + 1 : STARVE_MAX) : 0;
        mw = d_write; maddr = d_addr; mwd = d_wdata; mf3 = d_funct3;
      end else mstarve = 0;
    end else if (m_ack) mbusy = 0;
    else if (mfetch && i_flush) mdrop = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    step();
    step();
    rst = 0;
    step();
    // Single fetch, ack three cycles into m_req
    seen.delete();
    i_req = 1; i_addr = 64'h8000_0000;
    step();
    for (int k = 1; k <= 3; k++) begin
      m_ack = (k == 3);
      m_rdata = (k == 3) ? 64'h1234 : 64'h0;
      if (k == 3) begin
        #1;
        check("f_ivalid", 64'(i_valid), 64'(1));
        check("f_irdata", i_rdata, 64'h1234);
      end
      step();
    end
    i_req = 0; m_ack = 0;
    step();
    check("f_order", seen_str(), 64'("I"));
    // Simultaneous requests: D first, I right after
    seen.delete();
    i_req = 1; i_addr = 64'h2000; d_req = 1; d_write = 0; d_addr = 64'h40; d_funct3 = 3'b011;
    step();
    step();
    m_ack = 1; m_rdata = 64'h55;
    step();
    d_req = 0; m_ack = 0;
    step();
    m_ack = 1; m_rdata = 64'h66;
    step();
    i_req = 0; m_ack = 0;
    step();
    check("both_order", seen_str(), 64'("DI"));
    // Starvation bound: continuous D traffic with a waiting fetch
    seen.delete();
    d_req = 1; d_write = 0; d_addr = 64'h80; i_req = 1; i_addr = 64'h3000;
    for (int c = 0; c < 40 && seen.size() < 6; c++) begin
      m_ack = mbusy;
      m_rdata = {$urandom, $urandom};
      step();
    end
    d_req = 0; i_req = 0; m_ack = 0;
    step();
    check("starve_order", seen_str(), 64'("DDDDID"));
    // Redirect one cycle after the fetch grant; bus still completes, result dropped
    seen.delete();
    i_req = 1; i_addr = 64'h4000;
    step();
    i_flush = 1;
    step();
    i_flush = 0; i_req = 0;
    for (int k = 1; k <= 4; k++) begin
      m_ack = (k == 4);
      m_rdata = 64'hBAD;
      if (k < 4) begin
        #1;
        check("drop_mreq", 64'(m_req), 64'(1));
      end
      step();
    end
    m_ack = 0; d_req = 1; d_write = 0; d_addr = 64'h500;
    step();
    m_ack = 1;
    step();
    d_req = 0; m_ack = 0;
    step();
    check("drop_order", seen_str(), 64'("D"));
    // Reset during a data access, late ack ignored
    seen.delete();
    d_req = 1; d_write = 0; d_addr = 64'h600;
    step();
    step();
    rst = 1;
    step();
    rst = 0; d_req = 0; m_ack = 1; m_rdata = 64'h77;
    #1;
    check("rst_mreq", 64'(m_req), 64'(0));
    check("rst_maddr", m_addr, 64'h0);
    check("rst_dvalid", 64'(d_valid), 64'(0));
    step();
    m_ack = 0;
    step();
    check("rst_order", seen_str(), 64'(0));
    // Store command fields on the bus
    seen.delete();
    d_req = 1; d_write = 1; d_addr = 64'h100; d_wdata = 64'hDEAD; d_funct3 = 3'b010;
    step();
    for (int k = 1; k <= 3; k++) begin
      m_ack = (k == 3);
      #1;
      check("st_write", 64'(m_write), 64'(1));
      check("st_addr", m_addr, 64'h100);
      check("st_wdata", m_wdata, 64'hDEAD);
      check("st_funct3", 64'(m_funct3), 64'(3'b010));
      step();
    end
    d_req = 0; m_ack = 0;
    step();
    check("st_order", seen_str(), 64'("D"));
    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (last_iv || last_fl || last_rst || !i_req) begin
        i_req = ($urandom_range(0, 2) != 0);
        i_addr = {$urandom, $urandom};
      end
      if (last_dv || last_rst || !d_req) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_write = 1'($urandom_range(0, 1));
        d_addr = {$urandom, $urandom};
        d_wdata = {$urandom, $urandom};
        d_funct3 = 3'($urandom_range(0, 7));
      end
      i_flush = ($urandom_range(0, 7) == 0);
      m_ack = mbusy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      m_rdata = {$urandom, $urandom};
      last_fl = i_flush;
      last_rst = rst;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
